branch_resolution_unit: RTL and testbench

- Downstream consumer of the fetch-stage branch predictor outputs (PredictedTakenF, PredictedBTAF).
- Carries each fetched instruction's prediction through the Decode and Execute pipeline registers.
- In Execute, compares the prediction against the actual branch outcome and raises a mispredict with the corrected fetch PC.
- Drives the PC-select/redirect logic and the D/E flush requests of the hazard unit.

---
 rtl/branch_resolution_unit.sv | 162 ++++++++++++++++
 tb/tb_branch_resolution_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
// Carries the fetch-stage prediction of each instruction through the Decode
// and Execute pipeline registers. In Execute it compares the prediction with
// the real outcome and, when they disagree, raises MispredictE with the
// corrected fetch PC. It also requests D/E flushes from the hazard unit.
//
// Optional feature macro: BRU_PERF_COUNTERS_EN
//   When defined, adds registered BranchCount and MispredictCount outputs.
//   When undefined, those ports and their registers are absent.
`timescale 1ns/1ps

module branch_resolution_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            PredictedTakenF,
  input  logic [XLEN-1:0] PredictedBTAF,
  input  logic            ValidF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            IsBranchE,
  input  logic            ActualTakenE,
  input  logic [XLEN-1:0] ActualBTAE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic            FlushReqD,
  output logic            FlushReqE
`ifdef BRU_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
`endif
);

  // Decode-stage prediction registers
  logic            valid_d_q, valid_d_d;
  logic            pred_taken_d_q, pred_taken_d_d;
  logic [XLEN-1:0] pred_bta_d_q, pred_bta_d_d;

  // Execute-stage prediction registers
  logic            valid_e_q, valid_e_d;
  logic            pred_taken_e_q, pred_taken_e_d;
  logic [XLEN-1:0] pred_bta_e_q, pred_bta_e_d;

  // Resolution results
  logic            mispredict;
  logic            actual_taken_eff;
  logic            dir_wrong;
  logic            target_wrong;
  logic            alias_wrong;
  logic [XLEN-1:0] redirect_pc;

  // Compare the E-stage prediction against the real outcome; bubbles never mispredict
  always_comb begin
    actual_taken_eff = IsBranchE & ActualTakenE;
    dir_wrong        = IsBranchE & (pred_taken_e_q != ActualTakenE);
    target_wrong     = IsBranchE & pred_taken_e_q & ActualTakenE &
                       (pred_bta_e_q != ActualBTAE);
    alias_wrong      = ~IsBranchE & pred_taken_e_q;
    mispredict       = valid_e_q & (dir_wrong | target_wrong | alias_wrong);
  end

  // Pick the correct next fetch PC, zeroed whenever there is nothing to redirect
  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      if (actual_taken_eff) begin
        redirect_pc = ActualBTAE;
      end else begin
        redirect_pc = PCPlus4E;
      end
    end
  end

  assign MispredictE = mispredict;
  assign RedirectPCE = redirect_pc;
  assign FlushReqD   = mispredict;
  assign FlushReqE   = mispredict;

  // Next D contents: a flush or our own mispredict clears, a stall holds, otherwise load F
  always_comb begin
    valid_d_d      = valid_d_q;
    pred_taken_d_d = pred_taken_d_q;
    pred_bta_d_d   = pred_bta_d_q;
    if (FlushD || mispredict) begin
      valid_d_d      = 1'b0;
      pred_taken_d_d = 1'b0;
      pred_bta_d_d   = '0;
    end else if (!StallD) begin
      valid_d_d      = ValidF;
      pred_taken_d_d = PredictedTakenF;
      pred_bta_d_d   = PredictedBTAF;
    end
  end

  // Next E contents: a flush or our own mispredict clears, otherwise take D (E never stalls)
  always_comb begin
    valid_e_d      = valid_d_q;
    pred_taken_e_d = pred_taken_d_q;
    pred_bta_e_d   = pred_bta_d_q;
    if (FlushE || mispredict) begin
      valid_e_d      = 1'b0;
      pred_taken_e_d = 1'b0;
      pred_bta_e_d   = '0;
    end
  end

  // Pipeline registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_d_q      <= 1'b0;
      pred_taken_d_q <= 1'b0;
      pred_bta_d_q   <= '0;
      valid_e_q      <= 1'b0;
      pred_taken_e_q <= 1'b0;
      pred_bta_e_q   <= '0;
    end else begin
      valid_d_q      <= valid_d_d;
      pred_taken_d_q <= pred_taken_d_d;
      pred_bta_d_q   <= pred_bta_d_d;
      valid_e_q      <= valid_e_d;
      pred_taken_e_q <= pred_taken_e_d;
      pred_bta_e_q   <= pred_bta_e_d;
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  // Count resolved branches and mispredicts; both wrap naturally at full width
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (valid_e_q && IsBranchE) begin
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    end
    if (mispredict) begin
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign BranchCount     = branch_count_q;
  assign MispredictCount = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit
// Directed vector table for the documented scenarios, a hand-written
// asynchronous-reset sequence, then randomized traffic compared against a
// behavioural model of the two-slot prediction pipeline.
// Define BRU_PERF_COUNTERS_EN to also check the performance counters.
`timescale 1ns/1ps

module tb_branch_resolution_unit;

  localparam int XLEN = 32;
  localparam int CNT_WIDTH = 32;
  localparam logic [31:0] PROBE_BTA = 32'hDEAD_BEE0;
  localparam int NUM_VECS = 20;
  localparam int NUM_RANDOM = 400;

  logic            CLK;
  logic            RESET;
  logic            PredictedTakenF;
  logic [XLEN-1:0] PredictedBTAF;
  logic            ValidF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic            IsBranchE;
  logic            ActualTakenE;
  logic [XLEN-1:0] ActualBTAE;
  logic [XLEN-1:0] PCPlus4E;
  logic            MispredictE;
  logic [XLEN-1:0] RedirectPCE;
  logic            FlushReqD;
  logic            FlushReqE;
`ifdef BRU_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] BranchCount;
  logic [CNT_WIDTH-1:0] MispredictCount;
`endif

  branch_resolution_unit #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PredictedTakenF (PredictedTakenF),
    .PredictedBTAF   (PredictedBTAF),
    .ValidF          (ValidF),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .IsBranchE       (IsBranchE),
    .ActualTakenE    (ActualTakenE),
    .ActualBTAE      (ActualBTAE),
    .PCPlus4E        (PCPlus4E),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .FlushReqD       (FlushReqD),
    .FlushReqE       (FlushReqE)
`ifdef BRU_PERF_COUNTERS_EN
    ,
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
`endif
  );

  // Free-running clock, 10 ns period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        valid_f;
    logic        taken_f;
    logic [31:0] bta_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic        is_br;
    logic        act_taken;
    logic [31:0] act_bta;
    logic [31:0] pc4;
    logic        exp_mp;
    logic [31:0] exp_red;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        taken;
    logic [31:0] bta;
  } slot_t;

  vec_t vecs [NUM_VECS];
  slot_t model_d;
  slot_t model_e;
  int unsigned model_branches;
  int unsigned model_mispredicts;
  int n_checks;
  int n_fail;

  function automatic vec_t row(logic vf, logic tf, logic [31:0] bf,
                               logic st, logic fd, logic fe,
                               logic ib, logic at, logic [31:0] ab, logic [31:0] p4,
                               logic emp, logic [31:0] ered);
    vec_t v;
    v.valid_f = vf; v.taken_f = tf; v.bta_f = bf;
    v.stall_d = st; v.flush_d = fd; v.flush_e = fe;
    v.is_br = ib; v.act_taken = at; v.act_bta = ab; v.pc4 = p4;
    v.exp_mp = emp; v.exp_red = ered;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic exp_mp, input logic [31:0] exp_red);
    check({tag, " MispredictE"}, 64'(MispredictE), 64'(exp_mp));
    check({tag, " RedirectPCE"}, 64'(RedirectPCE), 64'(exp_red));
    check({tag, " FlushReqD"}, 64'(FlushReqD), 64'(exp_mp));
    check({tag, " FlushReqE"}, 64'(FlushReqE), 64'(exp_mp));
  endtask

  task automatic check_counters(input string tag);
`ifdef BRU_PERF_COUNTERS_EN
    check({tag, " BranchCount"}, 64'(BranchCount), 64'(model_branches));
    check({tag, " MispredictCount"}, 64'(MispredictCount), 64'(model_mispredicts));
`else
    if (tag.len() < 0) $display("[TB] unreachable");
`endif
  endtask

  task automatic apply_stimulus(input vec_t v);
    ValidF          = v.valid_f;
    PredictedTakenF = v.taken_f;
    PredictedBTAF   = v.bta_f;
    StallD          = v.stall_d;
    FlushD          = v.flush_d;
    FlushE          = v.flush_e;
    IsBranchE       = v.is_br;
    ActualTakenE    = v.act_taken;
    ActualBTAE      = v.act_bta;
    PCPlus4E        = v.pc4;
  endtask

  // Reference: a prediction is wrong when the predicted direction differs from
  // the effective direction (non-branches are "not taken"), or when both say
  // taken but the targets differ. Empty slots never resolve.
  function automatic logic model_mispredict();
    logic eff_taken;
    eff_taken = IsBranchE && ActualTakenE;
    if (!model_e.valid) return 1'b0;
    if (model_e.taken != eff_taken) return 1'b1;
    return model_e.taken && (model_e.bta != ActualBTAE);
  endfunction

  function automatic logic [31:0] model_redirect(input logic mp);
    if (!mp) return 32'h0;
    return (IsBranchE && ActualTakenE) ? ActualBTAE : PCPlus4E;
  endfunction

  task automatic model_reset();
    model_d = '{valid: 1'b0, taken: 1'b0, bta: 32'h0};
    model_e = '{valid: 1'b0, taken: 1'b0, bta: 32'h0};
    model_branches = 0;
    model_mispredicts = 0;
  endtask

  task automatic model_clock(input logic mp);
    slot_t empty;
    slot_t fetched;
    empty = '{valid: 1'b0, taken: 1'b0, bta: 32'h0};
    fetched = '{valid: ValidF, taken: PredictedTakenF, bta: PredictedBTAF};
    if (model_e.valid && IsBranchE) model_branches++;
    if (mp) model_mispredicts++;
    model_e = (FlushE || mp) ? empty : model_d;
    if (FlushD || mp) model_d = empty;
    else if (!StallD) model_d = fetched;
  endtask

  // One cycle: inputs already driven at posedge+1, check mid-cycle, advance model at the edge
  task automatic run_cycle(input string tag, input logic use_table, input logic exp_mp,
                           input logic [31:0] exp_red);
    logic mp;
    #4;
    mp = model_mispredict();
    if (use_table) check_output(tag, exp_mp, exp_red);
    else check_output(tag, mp, model_redirect(mp));
    check_counters(tag);
    @(posedge CLK);
    model_clock(mp);
    #1;
  endtask

  task automatic set_probe(input logic [31:0] pc4);
    ValidF = 1'b0; PredictedTakenF = 1'b0; PredictedBTAF = '0;
    StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    IsBranchE = 1'b1; ActualTakenE = 1'b1; ActualBTAE = PROBE_BTA; PCPlus4E = pc4;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_reset();

    vecs[0]  = row(1,1,32'h100, 0,0,0, 1,1,32'h100,  32'h04, 0,32'h0);
    vecs[1]  = row(0,0,32'h0,   0,0,0, 1,1,PROBE_BTA,32'h08, 0,32'h0);
    vecs[2]  = row(1,0,32'h0,   0,0,0, 1,1,32'h100,  32'h44, 0,32'h0);
    vecs[3]  = row(0,0,32'h0,   0,0,0, 1,1,32'h2000, 32'h44, 0,32'h0);
    vecs[4]  = row(1,1,32'h999, 0,0,0, 1,1,32'h2000, 32'h44, 1,32'h2000);
    vecs[5]  = row(1,1,32'h80,  0,0,0, 1,1,PROBE_BTA,32'h48, 0,32'h0);
    vecs[6]  = row(0,0,32'h0,   0,0,0, 1,1,PROBE_BTA,32'h4C, 0,32'h0);
    vecs[7]  = row(1,1,32'h700, 0,0,0, 1,1,32'h90,   32'h64, 1,32'h90);
    vecs[8]  = row(1,1,32'h50,  0,0,0, 0,0,32'h0,    32'h1C, 0,32'h0);
    vecs[9]  = row(0,0,32'h0,   0,0,0, 0,0,32'h0,    32'h1C, 0,32'h0);
    vecs[10] = row(0,0,32'h0,   0,0,1, 0,0,32'h1234, 32'h1C, 1,32'h1C);
    vecs[11] = row(1,1,32'h300, 0,0,0, 1,1,PROBE_BTA,32'h20, 0,32'h0);
    vecs[12] = row(1,0,32'h400, 1,0,1, 1,1,PROBE_BTA,32'h24, 0,32'h0);
    vecs[13] = row(1,1,32'h500, 1,0,1, 1,1,PROBE_BTA,32'h28, 0,32'h0);
    vecs[14] = row(0,0,32'h0,   0,0,0, 1,1,PROBE_BTA,32'h2C, 0,32'h0);
    vecs[15] = row(1,1,32'h600, 0,0,0, 1,1,32'h300,  32'h88, 0,32'h0);
    vecs[16] = row(1,1,32'h610, 0,0,0, 1,1,PROBE_BTA,32'h8C, 0,32'h0);
    vecs[17] = row(1,0,32'h0,   1,0,0, 1,0,32'h0,    32'h70, 1,32'h70);
    vecs[18] = row(0,0,32'h0,   0,0,0, 1,1,PROBE_BTA,32'h74, 0,32'h0);
    vecs[19] = row(0,0,32'h0,   0,0,0, 1,1,PROBE_BTA,32'h78, 0,32'h0);

    // Reset state with E inputs that would mispredict on any valid entry
    RESET = 1'b0;
    set_probe(32'h10);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_output("reset", 1'b0, 32'h0);
    check_counters("reset");
    RESET = 1'b1;

    // Directed scenarios, one row per cycle
    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i]);
      run_cycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp_mp, vecs[i].exp_red);
    end

    // Asynchronous reset while a mispredict is being signalled
    set_probe(32'h40);
    ValidF = 1'b1; PredictedTakenF = 1'b0; PredictedBTAF = 32'h0;
    run_cycle("arst_load", 1'b0, 1'b0, 32'h0);
    set_probe(32'h40);
    run_cycle("arst_move", 1'b0, 1'b0, 32'h0);
    ActualBTAE = 32'h2000;
    PCPlus4E   = 32'h44;
    #4;
    check_output("arst_pending", 1'b1, 32'h2000);
    #1;
    RESET = 1'b0;
    #1;
    check_output("arst_async", 1'b0, 32'h0);
    model_reset();
    check_counters("arst_async");
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    set_probe(32'h50);
    run_cycle("arst_after0", 1'b1, 1'b0, 32'h0);
    run_cycle("arst_after1", 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the behavioural model
    for (int i = 0; i < NUM_RANDOM; i++) begin
      ValidF          = ($urandom_range(0, 3) != 0);
      PredictedTakenF = $urandom_range(0, 1) != 0;
      PredictedBTAF   = 32'h100 * $urandom_range(1, 4);
      StallD          = ($urandom_range(0, 3) == 0);
      FlushD          = ($urandom_range(0, 9) == 0);
      FlushE          = ($urandom_range(0, 9) == 0);
      IsBranchE       = ($urandom_range(0, 9) < 7);
      ActualTakenE    = $urandom_range(0, 1) != 0;
      ActualBTAE      = 32'h100 * $urandom_range(1, 4);
      PCPlus4E        = {$urandom_range(0, 16'hFFFF), 2'b00};
      run_cycle($sformatf("rand%0d", i), 1'b0, 1'b0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
